updown_count_arbiter: RTL and testbench
=======================================

Name: updown_count_arbiter

Overview:
- Shares one WIDTH-bit up/down counter between N requesters.
- Each requester asks for a single increment or decrement. A round-robin arbiter grants one request per clock.
- The block applies the step, then returns a one-cycle ack, or a nack if the step would cross a boundary.
- Used wherever several agents (e.g. entry/exit sensors) update a shared occupancy or credit count.

Parameters:
- N, 3, number of requesters (2..8)
- WIDTH, 4, counter width in bits
- MAX_COUNT, 2**WIDTH-1, upper count limit (must be ≤ 2**WIDTH-1)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req  input  N  per-requester request; held until ack or nack is seen
- dir  input  N  per-requester step direction: 1 = up, 0 = down; stable while req is high
- ack  output  N  one-cycle pulse: the step was applied
- nack  output  N  one-cycle pulse: the step was refused (boundary)
- count  output  WIDTH  current counter value
- full  output  1  count == MAX_COUNT (combinational from count)
- empty  output  1  count == 0 (combinational from count)

Behaviour:
- Clocking: single clock clk. Reset is synchronous, active-high, sampled at the rising edge.
- Reset values:
  - count = 0, ack = 0, nack = 0.
  - Round-robin pointer = N-1, so requester 0 has first priority.
  - empty = 1, full = 0.
- Eligibility: eligible[i] = req[i] & ~ack[i] & ~nack[i]. A requester whose ack/nack is high this cycle cannot be re-granted in the same cycle, which prevents double steps.
- Grant: at most one per cycle. Search starts at pointer+1 mod N and takes the first eligible index. The pointer updates to the granted index only on a grant; with no grant it holds.
- Latency: request sampled at edge k → count updated and ack/nack asserted at edge k (visible in cycle k+1). Minimum back-to-back rate from one requester is one step every 2 cycles.
- Step rules for granted g:
  - dir=1 and count < MAX_COUNT: count+1, ack[g]=1.
  - dir=1 and count == MAX_COUNT: count unchanged, nack[g]=1 (see optional feature).
  - dir=0 and count > 0: count-1, ack[g]=1.
  - dir=0 and count == 0: count unchanged, nack[g]=1.
- ack and nack are never both high for the same index. At most one bit of ack|nack is high per cycle.
- Simultaneous opposite requests (one up, one down) are served sequentially in round-robin order, never netted in one cycle.
- Dropping a request: if req drops before grant, nothing happens. Dropping req while ack is high is the normal handshake.
- Reset mid-operation: reset wins over any grant in that cycle. ack/nack are cleared and pending requests are re-arbitrated from requester 0 after reset releases.

Optional Feature:
- Macro: UPDOWN_COUNT_WRAP_EN
- Defined: boundary steps wrap instead of being refused.
  - Up at MAX_COUNT → 0, with ack.
  - Down at 0 → MAX_COUNT, with ack.
  - nack is tied to 0.
- Undefined: saturating/refusing behaviour as specified in Behaviour.

Decomposition:
- Shared package: DIR_UP = 1'b1, DIR_DOWN = 1'b0 constants; a default-width constant for count.
- One sub-module, rr_arbiter: N-bit request vector in, one-hot grant plus valid out, internal pointer, and the same clk and synchronous reset.
- Counter update, boundary checks and ack/nack registers stay in the top module.

Test Plan:
- Reset then single up: reset 1 for 2 cycles; req[0]=1, dir[0]=1, dropped on ack → ack[0] pulses once, count 0→1, empty 1→0.
- Round-robin fairness: all three requesters hold req with dir=1 from count 0, each re-requesting immediately after its ack → ack order 0,1,2,0,1,2; count reaches 6 after 6 acks; no index acked twice consecutively while others wait.
- Lower boundary: count=0; req[1] with dir=0 → nack[1] pulses, count stays 0. Same stimulus with UPDOWN_COUNT_WRAP_EN defined → ack[1], count = 15.
- Upper boundary: drive count to 15 (MAX_COUNT default); req[2] with dir=1 → nack[2], full=1, count 15. With wrap enabled → count 0, empty=1.
- Simultaneous opposite: count=5; req[0] up and req[1] down in the same cycle → two sequential acks (0 then 1, pointer at reset state), count 5→6→5.
- Reset mid-operation: reset asserted in the same cycle as an eligible request → no ack/nack, count = 0. The held request is acked on the first cycle after reset deasserts.

Source files
------------

// File: rtl/updown_count_arbiter_pkg.sv
// rtl/updown_count_arbiter_pkg.sv - shared constants for the up/down count arbiter
package updown_count_arbiter_pkg;

    localparam logic DIR_UP          = 1'b1;
    localparam logic DIR_DOWN        = 1'b0;
    localparam int   COUNT_WIDTH_DEF = 4;

endpackage

// File: rtl/updown_count_arbiter_rr_arbiter.sv
// rtl/updown_count_arbiter_rr_arbiter.sv - round-robin arbiter, one-hot grant, pointer moves only on grant
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant,
    output logic         valid
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] grant_idx;

    // Search begins just past the last winner so every requester gets a turn.
    always_comb begin
        grant     = '0;
        valid     = 1'b0;
        grant_idx = ptr;
        for (int k = 1; k <= N; k++) begin
            if (!valid && req[(int'(ptr) + k) % N]) begin
                valid                        = 1'b1;
                grant[(int'(ptr) + k) % N]   = 1'b1;
                grant_idx                    = PW'((int'(ptr) + k) % N);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= PW'(N - 1);
        end else if (valid) begin
            ptr <= grant_idx;
        end
    end

endmodule

// File: rtl/updown_count_arbiter.sv
// rtl/updown_count_arbiter.sv - shared up/down counter with round-robin step arbitration (option: UPDOWN_COUNT_WRAP_EN)
module updown_count_arbiter
    import updown_count_arbiter_pkg::*;
#(
    parameter int N         = 3,
    parameter int WIDTH     = COUNT_WIDTH_DEF,
    parameter int MAX_COUNT = 2**WIDTH - 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     dir,
    output logic [N-1:0]     ack,
    output logic [N-1:0]     nack,
    output logic [WIDTH-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_COUNT);

    logic [N-1:0] eligible;
    logic [N-1:0] grant;
    logic         grant_valid;
    logic         grant_dir;

    // A requester being answered this cycle is masked so it cannot step twice.
    assign eligible  = req & ~ack & ~nack;
    assign grant_dir = |(grant & dir);

    rr_arbiter #(.N(N)) u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (eligible),
        .grant (grant),
        .valid (grant_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            ack   <= '0;
            nack  <= '0;
        end else begin
            ack  <= '0;
            nack <= '0;
            if (grant_valid) begin
                if (grant_dir == DIR_UP) begin
                    if (count != MAX_C) begin
                        count <= count + WIDTH'(1);
                        ack   <= grant;
                    end else begin
`ifdef UPDOWN_COUNT_WRAP_EN
                        count <= '0;
                        ack   <= grant;
`else
                        nack  <= grant;
`endif
                    end
                end else begin
                    if (count != '0) begin
                        count <= count - WIDTH'(1);
                        ack   <= grant;
                    end else begin
`ifdef UPDOWN_COUNT_WRAP_EN
                        count <= MAX_C;
                        ack   <= grant;
`else
                        nack  <= grant;
`endif
                    end
                end
            end
        end
    end

    assign full  = (count == MAX_C);
    assign empty = (count == '0);

endmodule

// File: tb/tb_updown_count_arbiter.sv
// tb/tb_updown_count_arbiter.sv - self-checking bench for updown_count_arbiter (option: UPDOWN_COUNT_WRAP_EN)
module tb_updown_count_arbiter;

    localparam int N     = 3;
    localparam int WIDTH = 4;
    localparam int MAX   = 15;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [N-1:0]     req = '0;
    logic [N-1:0]     dir = '0;
    logic [N-1:0]     ack;
    logic [N-1:0]     nack;
    logic [WIDTH-1:0] count;
    logic             full;
    logic             empty;

    int total = 0;
    int bad   = 0;

    updown_count_arbiter #(.N(N), .WIDTH(WIDTH), .MAX_COUNT(MAX)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .dir   (dir),
        .ack   (ack),
        .nack  (nack),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: occupancy as a plain integer, last winner as an index.
    int           m_count   = 0;
    int           m_last    = N - 1;
    logic [N-1:0] m_ack     = '0;
    logic [N-1:0] m_nack    = '0;
    bit           m_started = 1'b0;

    always @(posedge clk) begin : model
        int g;
        logic [N-1:0] elig;
        if (reset) begin
            m_count = 0;
            m_last  = N - 1;
            m_ack   = '0;
            m_nack  = '0;
        end else begin
            elig   = req & ~m_ack & ~m_nack;
            m_ack  = '0;
            m_nack = '0;
            g      = -1;
            for (int k = 1; k <= N; k++)
                if (g < 0 && elig[(m_last + k) % N]) g = (m_last + k) % N;
            if (g >= 0) begin
                m_last = g;
                if (dir[g]) begin
                    if (m_count < MAX) begin m_count = m_count + 1; m_ack[g] = 1'b1; end
`ifdef UPDOWN_COUNT_WRAP_EN
                    else begin m_count = 0; m_ack[g] = 1'b1; end
`else
                    else m_nack[g] = 1'b1;
`endif
                end else begin
                    if (m_count > 0) begin m_count = m_count - 1; m_ack[g] = 1'b1; end
`ifdef UPDOWN_COUNT_WRAP_EN
                    else begin m_count = MAX; m_ack[g] = 1'b1; end
`else
                    else m_nack[g] = 1'b1;
`endif
                end
            end
        end
        m_started = 1'b1;
    end

    always @(negedge clk) begin
        if (m_started) begin
            chk("ack",   int'(ack),   int'(m_ack));
            chk("nack",  int'(nack),  int'(m_nack));
            chk("count", int'(count), m_count);
            chk("full",  int'(full),  int'(m_count == MAX));
            chk("empty", int'(empty), int'(m_count == 0));
            chk("one_response", int'($countones(ack | nack) <= 1), 1);
        end
    end

    // Response log: index for ack, index+8 for nack, with count after the step.
    int log_code[$];
    int log_cnt[$];
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (ack[i])  begin log_code.push_back(i);     log_cnt.push_back(int'(count)); end
            if (nack[i]) begin log_code.push_back(i + 8); log_cnt.push_back(int'(count)); end
        end
    end

    // Requester agents: each holds req until its pending steps are answered.
    int           pend[N] = '{default: 0};
    logic [N-1:0] pend_dir = '0;
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (req[i] && (m_ack[i] || m_nack[i]) && pend[i] > 0) pend[i]--;
            req[i] = (pend[i] > 0);
            dir[i] = pend_dir[i];
        end
    end

    function automatic int pend_sum();
        int s = 0;
        for (int i = 0; i < N; i++) s += pend[i];
        return s;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int c = 0;
        do begin
            step();
            c++;
        end while (pend_sum() > 0 && c < 200);
        chk({name, "_idle"}, pend_sum(), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic chk_log(input string name, input int codes[], input int cnts[]);
        chk({name, "_len"}, log_code.size(), codes.size());
        for (int i = 0; i < codes.size() && i < log_code.size(); i++) begin
            chk({name, "_who"}, log_code[i], codes[i]);
            chk({name, "_cnt"}, log_cnt[i], cnts[i]);
        end
    endtask

    initial begin
        step();
        step();
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full",  int'(full),  0);
        chk("rst_ack",   int'(ack | nack), 0);
        reset = 1'b0;

        log_code.delete(); log_cnt.delete();
        pend_dir[0] = 1'b1; pend[0] = 1;
        wait_idle("single");
        chk_log("single", '{0}, '{1});
        chk("single_empty", int'(empty), 0);

        do_reset();
        log_code.delete(); log_cnt.delete();
        pend_dir = '1;
        for (int i = 0; i < N; i++) pend[i] = 2;
        wait_idle("fair");
        chk_log("fair", '{0, 1, 2, 0, 1, 2}, '{1, 2, 3, 4, 5, 6});

        do_reset();
        log_code.delete(); log_cnt.delete();
        pend_dir[1] = 1'b0; pend[1] = 1;
        wait_idle("lower");
`ifdef UPDOWN_COUNT_WRAP_EN
        chk_log("lower", '{1}, '{15});
`else
        chk_log("lower", '{9}, '{0});
`endif

        do_reset();
        pend_dir[0] = 1'b1; pend[0] = 15;
        wait_idle("fill");
        chk("fill_full", int'(full), 1);
        log_code.delete(); log_cnt.delete();
        pend_dir[2] = 1'b1; pend[2] = 1;
        wait_idle("upper");
`ifdef UPDOWN_COUNT_WRAP_EN
        chk_log("upper", '{2}, '{0});
        chk("upper_empty", int'(empty), 1);
`else
        chk_log("upper", '{10}, '{15});
        chk("upper_full", int'(full), 1);
`endif

        do_reset();
        pend_dir[2] = 1'b1; pend[2] = 5;
        wait_idle("to5");
        chk("to5_count", int'(count), 5);
        log_code.delete(); log_cnt.delete();
        pend_dir[0] = 1'b1; pend_dir[1] = 1'b0;
        pend[0] = 1; pend[1] = 1;
        wait_idle("opp");
        chk_log("opp", '{0, 1}, '{6, 5});

        pend_dir[0] = 1'b1; pend[0] = 1;
        reset = 1'b1;
        step();
        chk("midrst_resp",  int'(ack | nack), 0);
        chk("midrst_count", int'(count), 0);
        reset = 1'b0;
        step();
        chk("midrst_ack",   int'(ack), 1);
        chk("midrst_after", int'(count), 1);
        wait_idle("midrst");

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
